// File: rtl/register_file_pkg.sv
// Shared widths, register indices and the r7 update-op decode for the register file.
package register_file_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] addr_t;

  localparam addr_t REG_SP           = 3'd7;
  localparam data_t SP_RESET_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    SP_HOLD = 2'd0,
    SP_LOAD = 2'd1,
    SP_INC  = 2'd2,
    SP_DEC  = 2'd3
  } sp_op_e;

  // A write to r7 outranks stack arithmetic; inc together with dec cancels out.
  function automatic sp_op_e sp_op_decode(input logic wr_sp, input logic inc, input logic dec);
    sp_op_e op;
    casez ({wr_sp, inc, dec})
      3'b1??:  op = SP_LOAD;
      3'b010:  op = SP_INC;
      3'b001:  op = SP_DEC;
      default: op = SP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/register_file_mux_8way.sv
// Eight-input operand select used by each register file read port.
module mux_8way
  import register_file_pkg::*;
(
  input  data_t opts [NUM_REGS],
  input  addr_t sel,
  output data_t result
);

  // Select one of the eight register values.
  always_comb begin
    result = opts[0];
    case (sel)
      3'd0:    result = opts[0];
      3'd1:    result = opts[1];
      3'd2:    result = opts[2];
      3'd3:    result = opts[3];
      3'd4:    result = opts[4];
      3'd5:    result = opts[5];
      3'd6:    result = opts[6];
      3'd7:    result = opts[7];
      default: result = opts[0];
    endcase
  end

endmodule

// File: rtl/register_file.sv
// Eight 8-bit registers with r7 as stack pointer: one write port, two bypassed read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter data_t SP_RESET = SP_RESET_DEFAULT,
  parameter bit    BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [2:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              sp_inc,
  input  logic              sp_dec,
  output logic [DATA_W-1:0] sp_out
);

  data_t  regs_r [NUM_REGS];
  data_t  r7_next_s;
  sp_op_e sp_op_s;
  logic   wr_sp_s;
  data_t  mux_a_s;
  data_t  mux_b_s;

  // Next value of r7 from write / increment / decrement requests.
  always_comb begin
    wr_sp_s   = wr_en && (wr_addr == REG_SP);
    sp_op_s   = sp_op_decode(wr_sp_s, sp_inc, sp_dec);
    r7_next_s = regs_r[REG_SP];
    case (sp_op_s)
      SP_LOAD: r7_next_s = wr_data;
      SP_INC:  r7_next_s = regs_r[REG_SP] + 8'd1;
      SP_DEC:  r7_next_s = regs_r[REG_SP] - 8'd1;
      SP_HOLD: r7_next_s = regs_r[REG_SP];
      default: r7_next_s = regs_r[REG_SP];
    endcase
  end

  // Register storage; r7 takes its own next-state path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs_r[i] <= 8'h00;
      end
      regs_r[REG_SP] <= SP_RESET;
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (wr_en && (wr_addr == addr_t'(i))) begin
          regs_r[i] <= wr_data;
        end
      end
      regs_r[REG_SP] <= r7_next_s;
    end
  end

  mux_8way u_mux_a (
    .opts   (regs_r),
    .sel    (rd_addr_a),
    .result (mux_a_s)
  );

  mux_8way u_mux_b (
    .opts   (regs_r),
    .sel    (rd_addr_b),
    .result (mux_b_s)
  );

  // Same-cycle write forwarding; held off during reset so reads show reset contents.
  always_comb begin
    if (BYPASS && rst_n && wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = mux_a_s;
    end
    if (BYPASS && rst_n && wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = mux_b_s;
    end
  end

  assign sp_out = regs_r[REG_SP];

endmodule

// File: tb/tb_register_file.sv
// Directed and randomised checks of register_file against hand-computed values and a small model.
module tb_register_file;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr_a;
  logic [7:0] rd_data_a;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_b;
  logic       sp_inc;
  logic       sp_dec;
  logic [7:0] sp_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] m [8];

  register_file #(.SP_RESET(8'hFF), .BYPASS(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .sp_inc    (sp_inc),
    .sp_dec    (sp_dec),
    .sp_out    (sp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    sp_inc = 1'b0;
    sp_dec = 1'b0;
  endtask

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    if (wr_en && wr_addr == a) return wr_data;
    return m[a];
  endfunction

  initial begin
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hAA;
    sp_inc = 1'b1; sp_dec = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd7;

    // Reset held across edges: reset contents on every address, no bypass.
    repeat (2) @(posedge clk);
    #2;
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(7 - a);
      #1;
      check($sformatf("rst_a%0d", a), rd_data_a, (a == 7) ? 8'hFF : 8'h00);
      check($sformatf("rst_b%0d", 7 - a), rd_data_b, (a == 0) ? 8'hFF : 8'h00);
    end
    check("rst_sp", sp_out, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Write r3 with bypass in the write cycle, then registered read on both ports.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A; rd_addr_a = 3'd3; rd_addr_b = 3'd0;
    #1;
    check("wr_bypass_a", rd_data_a, 8'h5A);
    check("wr_other_b", rd_data_b, 8'h00);
    @(negedge clk);
    idle(); rd_addr_b = 3'd3;
    #1;
    check("rd3_a", rd_data_a, 8'h5A);
    check("rd3_b", rd_data_b, 8'h5A);

    // SP wrap up and down, inc not forwarded, inc+dec cancels.
    @(negedge clk);
    sp_inc = 1'b1; rd_addr_a = 3'd7;
    #1;
    check("sp_inc_nofwd", rd_data_a, 8'hFF);
    check("sp_pre", sp_out, 8'hFF);
    @(negedge clk);
    sp_inc = 1'b0; sp_dec = 1'b1;
    #1;
    check("sp_wrap_up", sp_out, 8'h00);
    @(negedge clk);
    #1;
    check("sp_wrap_dn", sp_out, 8'hFF);
    @(negedge clk);
    sp_dec = 1'b0;
    #1;
    check("sp_dec2", sp_out, 8'hFE);
    @(negedge clk);
    sp_inc = 1'b1; sp_dec = 1'b1;
    #1;
    check("sp_both_pre", sp_out, 8'hFE);
    @(negedge clk);
    idle();
    #1;
    check("sp_both", sp_out, 8'hFE);

    // Write to r7 beats sp_inc; a write elsewhere does not block sp_dec.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h40; sp_inc = 1'b1; rd_addr_a = 3'd7;
    #1;
    check("r7_bypass", rd_data_a, 8'h40);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h11; sp_inc = 1'b0; sp_dec = 1'b1;
    #1;
    check("r7_conflict", sp_out, 8'h40);
    @(negedge clk);
    idle(); rd_addr_a = 3'd1;
    #1;
    check("sp_dec_with_wr", sp_out, 8'h3F);
    check("r1_wr", rd_data_a, 8'h11);

    // Sweep: r0..r7 = 10..80, all 64 read-address pairs.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(10 * (i + 1));
    end
    @(negedge clk);
    idle();
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        rd_addr_a = 3'(a);
        rd_addr_b = 3'(b);
        #1;
        check($sformatf("sweep_a%0d", a), rd_data_a, 8'(10 * (a + 1)));
        check($sformatf("sweep_b%0d", b), rd_data_b, 8'(10 * (b + 1)));
      end
    end

    // Reset mid-cycle with a write and an SP increment pending: both lost.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h33; sp_inc = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd7;
    #1;
    check("pre_rst_bypass", rd_data_a, 8'h33);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_a", rd_data_a, 8'h00);
    check("midrst_b", rd_data_b, 8'hFF);
    check("midrst_sp", sp_out, 8'hFF);
    @(posedge clk);
    #1;
    check("midrst_hold_a", rd_data_a, 8'h00);
    check("midrst_hold_sp", sp_out, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(a);
      #1;
      check($sformatf("postrst_a%0d", a), rd_data_a, (a == 7) ? 8'hFF : 8'h00);
      check($sformatf("postrst_b%0d", a), rd_data_b, (a == 7) ? 8'hFF : 8'h00);
    end

    // Random traffic against a reference model.
    for (int i = 0; i < 7; i++) m[i] = 8'h00;
    m[7] = 8'hFF;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 8'($urandom_range(0, 255));
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = 3'($urandom_range(0, 7));
      sp_inc    = 1'($urandom_range(0, 1));
      sp_dec    = 1'($urandom_range(0, 1));
      #1;
      check("rnd_a", rd_data_a, exp_rd(rd_addr_a));
      check("rnd_b", rd_data_b, exp_rd(rd_addr_b));
      check("rnd_sp", sp_out, m[7]);
      if (wr_en && wr_addr != 3'd7) m[wr_addr] = wr_data;
      if (wr_en && wr_addr == 3'd7) m[7] = wr_data;
      else if (sp_inc && !sp_dec) m[7] = m[7] + 8'd1;
      else if (sp_dec && !sp_inc) m[7] = m[7] - 8'd1;
    end
    @(negedge clk);
    idle();
    #1;
    check("rnd_final_sp", sp_out, m[7]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
